vx_dma_unit: RTL and testbench

VX_DMA_UNIT -- requirements
Module: VX_dma_unit

---
 rtl/vx_dma_unit.sv | 166 ++++++++++++++++
 tb/tb_vx_dma_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_dma_unit.sv
// DMA dispatch unit: accepts one copy/WAIT instruction at a time, issues copies to the DMA engine,
// tracks outstanding copies per warp, and commits each instruction back to the pipeline.
module vx_dma_unit #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned SIZE_WIDTH  = 16,
  parameter int unsigned TAG_WIDTH   = 8,
  parameter int unsigned MAX_PENDING = 4,
  localparam int unsigned WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  disp_valid_i,
  output logic                  disp_ready_o,
  input  logic [WID_W-1:0]      disp_wid_i,
  input  logic [1:0]            disp_op_i,
  input  logic [TAG_WIDTH-1:0]  disp_tag_i,
  input  logic [ADDR_WIDTH-1:0] disp_src_i,
  input  logic [ADDR_WIDTH-1:0] disp_dst_i,
  input  logic [SIZE_WIDTH-1:0] disp_size_i,
  output logic                  dma_req_valid_o,
  input  logic                  dma_req_ready_i,
  output logic                  dma_req_dir_o,
  output logic [ADDR_WIDTH-1:0] dma_req_src_o,
  output logic [ADDR_WIDTH-1:0] dma_req_dst_o,
  output logic [SIZE_WIDTH-1:0] dma_req_size_o,
  output logic [WID_W-1:0]      dma_req_wid_o,
  input  logic                  dma_rsp_valid_i,
  input  logic [WID_W-1:0]      dma_rsp_wid_i,
  input  logic                  dma_rsp_error_i,
  output logic                  commit_valid_o,
  input  logic                  commit_ready_i,
  output logic [WID_W-1:0]      commit_wid_o,
  output logic [TAG_WIDTH-1:0]  commit_tag_o,
  output logic                  commit_error_o,
  output logic [NUM_WARPS-1:0]  warp_stall_o,
  output logic                  busy_o
);

  localparam int unsigned PW = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] MaxPend = PW'(MAX_PENDING);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StReq    = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StCommit = 2'd3;

  localparam logic [1:0] OpWait = 2'b10;
  localparam logic [1:0] OpRsvd = 2'b11;

  logic [1:0]            state_q, state_d;
  logic [1:0]            op_q;
  logic [WID_W-1:0]      wid_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [SIZE_WIDTH-1:0] size_q;
  logic                  cerr_q, cerr_d;
  logic [PW-1:0]         pend_q [NUM_WARPS];
  logic [PW-1:0]         pend_d [NUM_WARPS];
  logic [NUM_WARPS-1:0]  err_q, err_d;

  logic disp_is_copy, disp_fire, req_fire, commit_fire;

  assign disp_is_copy = !disp_op_i[1] && (disp_size_i != '0);
  assign disp_ready_o = (state_q == StIdle) && (!disp_is_copy || (pend_q[disp_wid_i] < MaxPend));
  assign disp_fire    = disp_valid_i && disp_ready_o;
  assign req_fire     = (state_q == StReq) && dma_req_ready_i;
  assign commit_fire  = (state_q == StCommit) && commit_ready_i;

  // A response in the same cycle as a WAIT commit re-sets the error bit it would have cleared.
  always_comb begin
    err_d = err_q;
    if (commit_fire && (op_q == OpWait)) err_d[wid_q] = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      pend_d[w] = pend_q[w];
      if (dma_rsp_valid_i && (dma_rsp_wid_i == WID_W'(w)) && dma_rsp_error_i) err_d[w] = 1'b1;
      if (req_fire && (wid_q == WID_W'(w)) &&
          !(dma_rsp_valid_i && (dma_rsp_wid_i == WID_W'(w)))) begin
        if (pend_q[w] != MaxPend) pend_d[w] = pend_q[w] + 1'b1;
      end else if (dma_rsp_valid_i && (dma_rsp_wid_i == WID_W'(w)) &&
                   !(req_fire && (wid_q == WID_W'(w)))) begin
        if (pend_q[w] == '0) err_d[w] = 1'b1;
        else                 pend_d[w] = pend_q[w] - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cerr_d  = cerr_q;
    case (state_q)
      StIdle: begin
        if (disp_fire) begin
          if (disp_op_i == OpRsvd) begin
            state_d = StCommit;
            cerr_d  = 1'b1;
          end else if (disp_op_i == OpWait) begin
            cerr_d  = err_d[disp_wid_i];
            state_d = (pend_q[disp_wid_i] == '0) ? StCommit : StWait;
          end else begin
            cerr_d  = 1'b0;
            state_d = (disp_size_i == '0) ? StCommit : StReq;
          end
        end
      end
      StReq:    if (dma_req_ready_i) state_d = StCommit;
      StWait: begin
        if (pend_q[wid_q] == '0) begin
          state_d = StCommit;
          cerr_d  = err_d[wid_q];
        end
      end
      StCommit: if (commit_ready_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      op_q    <= '0;
      wid_q   <= '0;
      tag_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      size_q  <= '0;
      cerr_q  <= 1'b0;
      err_q   <= '0;
      for (int w = 0; w < NUM_WARPS; w++) pend_q[w] <= '0;
    end else begin
      state_q <= state_d;
      cerr_q  <= cerr_d;
      err_q   <= err_d;
      for (int w = 0; w < NUM_WARPS; w++) pend_q[w] <= pend_d[w];
      if (disp_fire) begin
        op_q   <= disp_op_i;
        wid_q  <= disp_wid_i;
        tag_q  <= disp_tag_i;
        src_q  <= disp_src_i;
        dst_q  <= disp_dst_i;
        size_q <= disp_size_i;
      end
    end
  end

  assign dma_req_valid_o = (state_q == StReq);
  assign dma_req_dir_o   = op_q[0];
  assign dma_req_src_o   = src_q;
  assign dma_req_dst_o   = dst_q;
  assign dma_req_size_o  = size_q;
  assign dma_req_wid_o   = wid_q;

  assign commit_valid_o = (state_q == StCommit);
  assign commit_wid_o   = wid_q;
  assign commit_tag_o   = tag_q;
  assign commit_error_o = cerr_q;

  always_comb begin
    busy_o = (state_q != StIdle);
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_stall_o[w] = ((state_q == StWait) && (wid_q == WID_W'(w))) || (pend_q[w] == MaxPend);
      if (pend_q[w] != '0) busy_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_vx_dma_unit.sv
// Bench for vx_dma_unit: directed scenarios with literal checks plus a transaction-level model
// compared against the DUT outputs on every falling edge.
module tb_vx_dma_unit;
  localparam int NW = 4;
  localparam int MP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [1:0]  disp_wid = '0;
  logic [1:0]  disp_op = '0;
  logic [7:0]  disp_tag = '0;
  logic [31:0] disp_src = '0;
  logic [31:0] disp_dst = '0;
  logic [15:0] disp_size = '0;
  logic        dma_req_valid;
  logic        dma_req_ready = 1'b1;
  logic        dma_req_dir;
  logic [31:0] dma_req_src, dma_req_dst;
  logic [15:0] dma_req_size;
  logic [1:0]  dma_req_wid;
  logic        dma_rsp_valid = 1'b0;
  logic [1:0]  dma_rsp_wid = '0;
  logic        dma_rsp_error = 1'b0;
  logic        commit_valid;
  logic        commit_ready = 1'b1;
  logic [1:0]  commit_wid;
  logic [7:0]  commit_tag;
  logic        commit_error;
  logic [NW-1:0] warp_stall;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  vx_dma_unit dut (
    .clk_i(clk), .reset_i(rst),
    .disp_valid_i(disp_valid), .disp_ready_o(disp_ready), .disp_wid_i(disp_wid),
    .disp_op_i(disp_op), .disp_tag_i(disp_tag), .disp_src_i(disp_src), .disp_dst_i(disp_dst),
    .disp_size_i(disp_size),
    .dma_req_valid_o(dma_req_valid), .dma_req_ready_i(dma_req_ready), .dma_req_dir_o(dma_req_dir),
    .dma_req_src_o(dma_req_src), .dma_req_dst_o(dma_req_dst), .dma_req_size_o(dma_req_size),
    .dma_req_wid_o(dma_req_wid),
    .dma_rsp_valid_i(dma_rsp_valid), .dma_rsp_wid_i(dma_rsp_wid), .dma_rsp_error_i(dma_rsp_error),
    .commit_valid_o(commit_valid), .commit_ready_i(commit_ready), .commit_wid_o(commit_wid),
    .commit_tag_o(commit_tag), .commit_error_o(commit_error),
    .warp_stall_o(warp_stall), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired", name);
  endtask

  // Model: in-flight instruction record plus per-warp outstanding counts and sticky errors.
  int          m_pend [NW] = '{default: 0};
  bit          m_err  [NW] = '{default: 0};
  bit          m_active = 0, m_need_req = 0, m_wait_drain = 0, m_is_wait = 0, m_cerr = 0;
  logic [1:0]  m_wid = '0, m_op = '0;
  logic [7:0]  m_tag = '0;
  logic [31:0] m_src = '0, m_dst = '0;
  logic [15:0] m_size = '0;

  always @(posedge clk or posedge rst) begin
    int old_pend [NW];
    bit was_active, rdy, cfire, rfire, inc, dec;
    if (rst) begin
      for (int i = 0; i < NW; i++) begin
        m_pend[i] = 0;
        m_err[i]  = 0;
      end
      m_active = 0; m_need_req = 0; m_wait_drain = 0;
    end else begin
      old_pend   = m_pend;
      was_active = m_active;
      rfire = m_active && m_need_req && dma_req_ready;
      cfire = m_active && !m_need_req && !m_wait_drain && commit_ready;
      rdy   = !m_active && (disp_op[1] || disp_size == 0 || m_pend[disp_wid] < MP);
      if (cfire) begin
        m_active = 0;
        if (m_is_wait) m_err[m_wid] = 0;
      end
      for (int w = 0; w < NW; w++) begin
        inc = rfire && (m_wid == w);
        dec = dma_rsp_valid && (dma_rsp_wid == w);
        if (dec && dma_rsp_error) m_err[w] = 1;
        if (inc && !dec) m_pend[w] = (m_pend[w] < MP) ? m_pend[w] + 1 : MP;
        else if (dec && !inc) begin
          if (m_pend[w] == 0) m_err[w] = 1;
          else m_pend[w] = m_pend[w] - 1;
        end
      end
      if (rfire) m_need_req = 0;
      else if (m_active && m_wait_drain && old_pend[m_wid] == 0) begin
        m_wait_drain = 0;
        m_cerr = m_err[m_wid];
      end
      if (!was_active && disp_valid && rdy) begin
        m_active = 1; m_wid = disp_wid; m_op = disp_op; m_tag = disp_tag;
        m_src = disp_src; m_dst = disp_dst; m_size = disp_size;
        m_is_wait = (disp_op == 2'b10);
        m_need_req = 0; m_wait_drain = 0; m_cerr = 0;
        case (disp_op)
          2'b00, 2'b01: m_need_req = (disp_size != 0);
          2'b10: begin
            if (old_pend[disp_wid] == 0) m_cerr = m_err[disp_wid];
            else m_wait_drain = 1;
          end
          default: m_cerr = 1;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic [NW-1:0] stall_e;
    bit busy_e, cv_e;
    if (!rst && cmp_en) begin
      busy_e = m_active;
      for (int w = 0; w < NW; w++) begin
        stall_e[w] = (m_active && m_wait_drain && m_wid == w) || (m_pend[w] == MP);
        if (m_pend[w] != 0) busy_e = 1;
      end
      cv_e = m_active && !m_need_req && !m_wait_drain;
      chk("m_disp_ready", disp_ready,
          !m_active && (disp_op[1] || disp_size == 0 || m_pend[disp_wid] < MP));
      chk("m_req_valid", dma_req_valid, m_active && m_need_req);
      if (m_active && m_need_req) begin
        chk("m_req_dir", dma_req_dir, m_op[0]);
        chk("m_req_src", dma_req_src, m_src);
        chk("m_req_dst", dma_req_dst, m_dst);
        chk("m_req_size", dma_req_size, m_size);
        chk("m_req_wid", dma_req_wid, m_wid);
      end
      chk("m_commit_valid", commit_valid, cv_e);
      if (cv_e) begin
        chk("m_commit_wid", commit_wid, m_wid);
        chk("m_commit_tag", commit_tag, m_tag);
        chk("m_commit_error", commit_error, m_cerr);
      end
      chk("m_warp_stall", warp_stall, stall_e);
      chk("m_busy", busy, busy_e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [1:0] wid, input logic [1:0] op, input logic [7:0] tag,
                          input logic [31:0] src, input logic [31:0] dst, input logic [15:0] size);
    bit done;
    done = 0;
    disp_wid = wid; disp_op = op; disp_tag = tag;
    disp_src = src; disp_dst = dst; disp_size = size;
    disp_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (disp_ready) done = 1;
      step();
    end
    disp_valid = 1'b0;
    if (!done) fail("dispatch_timeout");
  endtask

  task automatic wait_commit();
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (commit_valid) done = 1;
      step();
    end
    if (!done) fail("commit_timeout");
  endtask

  task automatic rsp(input logic [1:0] wid, input logic err);
    dma_rsp_valid = 1'b1; dma_rsp_wid = wid; dma_rsp_error = err;
    step();
    dma_rsp_valid = 1'b0; dma_rsp_error = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_req_valid", dma_req_valid, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_warp_stall", warp_stall, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    step();

    // G2L copy on warp 1
    dispatch(2'd1, 2'b00, 8'd5, 32'h1000, 32'h40, 16'd64);
    chk("g2l_req_valid", dma_req_valid, 1);
    chk("g2l_req_dir", dma_req_dir, 0);
    chk("g2l_req_src", dma_req_src, 32'h1000);
    chk("g2l_req_dst", dma_req_dst, 32'h40);
    chk("g2l_req_size", dma_req_size, 64);
    chk("g2l_req_wid", dma_req_wid, 1);
    chk("g2l_no_commit_yet", commit_valid, 0);
    step();
    chk("g2l_commit_valid", commit_valid, 1);
    chk("g2l_commit_wid", commit_wid, 1);
    chk("g2l_commit_tag", commit_tag, 5);
    chk("g2l_commit_error", commit_error, 0);
    step();
    chk("g2l_busy_pending", busy, 1);

    // WAIT on warp 1 with response after 10 cycles
    dispatch(2'd1, 2'b10, 8'd6, 32'h0, 32'h0, 16'd0);
    for (int i = 0; i < 10; i++) begin
      chk("wait_stall", warp_stall[1], 1);
      chk("wait_no_commit", commit_valid, 0);
      step();
    end
    rsp(2'd1, 1'b0);
    chk("wait_drain_lag", commit_valid, 0);
    step();
    chk("wait_commit_valid", commit_valid, 1);
    chk("wait_commit_tag", commit_tag, 6);
    chk("wait_commit_error", commit_error, 0);
    step();
    chk("wait_idle_busy", busy, 0);

    // Four copies fill warp 0, fifth is held off
    for (int k = 0; k < 4; k++) begin
      dispatch(2'd0, 2'b00, 8'(10 + k), 32'(k * 256), 32'h0, 16'd16);
      wait_commit();
    end
    chk("full_stall", warp_stall[0], 1);
    disp_wid = 2'd0; disp_op = 2'b00; disp_tag = 8'd20; disp_size = 16'd16;
    disp_valid = 1'b1;
    chk("full_not_ready", disp_ready, 0);
    step();
    chk("full_not_ready2", disp_ready, 0);
    dma_rsp_valid = 1'b1; dma_rsp_wid = 2'd0;
    chk("full_rsp_cycle", disp_ready, 0);
    step();
    dma_rsp_valid = 1'b0;
    chk("full_ready_after_rsp", disp_ready, 1);
    chk("full_stall_clear", warp_stall[0], 0);
    step();
    disp_valid = 1'b0;
    wait_commit();
    for (int k = 0; k < 4; k++) rsp(2'd0, 1'b0);
    chk("full_drained", busy, 0);

    // Size-0 copy, sticky error, underflow, reserved op
    dispatch(2'd2, 2'b00, 8'd7, 32'h500, 32'h600, 16'd0);
    chk("zero_no_req", dma_req_valid, 0);
    chk("zero_commit", commit_valid, 1);
    chk("zero_tag", commit_tag, 7);
    step();
    dispatch(2'd3, 2'b01, 8'd8, 32'h10, 32'h20, 16'd4);
    wait_commit();
    rsp(2'd3, 1'b1);
    dispatch(2'd3, 2'b10, 8'd9, 32'h0, 32'h0, 16'd0);
    chk("err_wait_commit", commit_valid, 1);
    chk("err_wait_error", commit_error, 1);
    step();
    dispatch(2'd3, 2'b10, 8'd10, 32'h0, 32'h0, 16'd0);
    chk("err_cleared", commit_error, 0);
    step();
    rsp(2'd2, 1'b0);
    chk("underflow_busy", busy, 0);
    dispatch(2'd2, 2'b10, 8'd11, 32'h0, 32'h0, 16'd0);
    chk("underflow_error", commit_error, 1);
    step();
    dispatch(2'd1, 2'b11, 8'd12, 32'h0, 32'h0, 16'd8);
    chk("rsvd_no_req", dma_req_valid, 0);
    chk("rsvd_error", commit_error, 1);
    step();

    // Backpressured request, then fire alongside a response on the same warp
    dispatch(2'd0, 2'b00, 8'd13, 32'h30, 32'h40, 16'd8);
    wait_commit();
    dma_req_ready = 1'b0;
    dispatch(2'd0, 2'b01, 8'd14, 32'h2000, 32'h80, 16'd32);
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_valid", dma_req_valid, 1);
      chk("bp_req_src", dma_req_src, 32'h2000);
      chk("bp_req_dst", dma_req_dst, 32'h80);
      chk("bp_req_dir", dma_req_dir, 1);
      chk("bp_no_commit", commit_valid, 0);
      step();
    end
    dma_req_ready = 1'b1;
    dma_rsp_valid = 1'b1; dma_rsp_wid = 2'd0;
    step();
    dma_rsp_valid = 1'b0;
    chk("bp_commit_tag", commit_tag, 14);
    step();
    dispatch(2'd0, 2'b10, 8'd15, 32'h0, 32'h0, 16'd0);
    chk("same_cycle_pend_kept", commit_valid, 0);
    chk("same_cycle_stall", warp_stall[0], 1);
    step();
    rsp(2'd0, 1'b0);
    step();
    chk("same_cycle_commit", commit_valid, 1);
    chk("same_cycle_no_err", commit_error, 0);
    step();

    // Asynchronous reset while a request is outstanding
    dma_req_ready = 1'b0;
    dispatch(2'd1, 2'b00, 8'd16, 32'h70, 32'h80, 16'd8);
    chk("ar_req_before", dma_req_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_req_dropped", dma_req_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_disp_ready", disp_ready, 1);
    chk("ar_stall", warp_stall, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    dma_req_ready = 1'b1;
    step();
    rsp(2'd1, 1'b0);
    chk("ar_late_rsp_busy", busy, 0);
    dispatch(2'd1, 2'b10, 8'd17, 32'h0, 32'h0, 16'd0);
    chk("ar_late_rsp_err", commit_error, 1);
    step();
    dispatch(2'd1, 2'b10, 8'd18, 32'h0, 32'h0, 16'd0);
    chk("ar_err_cleared", commit_error, 0);
    step();

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
